// File: rtl/store_rmw_ctrl.sv
// CPU-to-DRAM store/load controller: sub-word stores do a read-modify-write, loads return the raw word.
// Latency: error +1, word store +2, sub-word store/load +3; ready is low while busy and requests are not queued.
module store_rmw_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] dram_addr,
   output logic        dram_we,
   output logic [31:0] dram_wd,
   input  logic [31:0] dram_rd
);

   typedef enum logic [2:0] {IDLE, RD, WR, CAP, RESP} state_t;

   state_t      state, state_nxt;
   logic        we_q;
   logic [1:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        err_q;
   logic        misalign;
   logic        accept;
   logic [31:0] merged;

   assign misalign = (op == 2'b11) ||
                     (op == 2'b01 && addr[0]) ||
                     (op == 2'b10 && addr[1:0] != 2'b00);
   assign accept   = req && (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         op_q    <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
         rdata   <= 32'h0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            we_q    <= we;
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            err_q   <= misalign;
         end
         // dram_rd here reflects the address presented during RD
         if (state == CAP) begin
            rdata <= dram_rd;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (misalign)                  state_nxt = RESP;
               else if (we && op == 2'b10)    state_nxt = WR;
               else                           state_nxt = RD;
            end
         end
         RD:      state_nxt = we_q ? WR : CAP;
         WR:      state_nxt = RESP;
         CAP:     state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Lane merge of the word fetched in RD; word stores bypass the read
   always_comb begin
      merged = dram_rd;
      case (op_q)
         2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
         2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   assign ready     = (state == IDLE);
   assign done      = (state == RESP);
   assign err       = done && err_q;
   assign dram_we   = (state == WR);
   assign dram_wd   = (state == WR) ? merged : 32'h0;
   assign dram_addr = (state != IDLE) ? {addr_q[31:2], 2'b00} : 32'h0;

endmodule
